hc595_scan_ctrl: RTL and testbench

HC595_SCAN_CTRL -- requirements
Module: hc595_scan_ctrl

---
 rtl/hc595_pkg.sv | 24 ++
 rtl/hc595_shifter.sv | 102 ++++++++++
 rtl/hc595_scan_ctrl.sv | 134 +++++++++++++
 tb/tb_hc595_scan_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hc595_pkg.sv
// Shared types and constants for the 74HC595 display scan controller.
package hc595_pkg;

  localparam int unsigned FRAME_W = 16;
  localparam int unsigned SEL_W   = 8;
  localparam int unsigned SEG_W   = 8;

  // Segment pattern shifted for a blanked frame and held in memory after reset.
  localparam logic [SEG_W-1:0] BLANK_SEG = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  // One serial frame: digit select byte goes out first, then segments.
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [SEG_W-1:0] seg;
  } frame_t;

endpackage

// File: rtl/hc595_shifter.sv
// N-bit PISO serializer with SH_CP/ST_CP phase generation.
// A frame is 2N+2 half-periods of CLK_DIV cycles: 2N shift halves
// (even = SH_CP low with new DS, odd = SH_CP high), one settle half with
// everything low, then one half with ST_CP high.
module hc595_shifter #(
  parameter int unsigned N       = 16,
  parameter int unsigned CLK_DIV = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] data,
  output logic         ds,
  output logic         sh_cp,
  output logic         st_cp,
  output logic         shift_done_c,
  output logic         done_c
);

  localparam int unsigned LAST_HALF = 2 * N + 1;
  localparam int unsigned HALF_W    = $clog2(LAST_HALF + 1);
  localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic              active_q, active_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [N-1:0]      sreg_q, sreg_d;
  logic              ds_q, ds_d;
  logic              sh_cp_q, sh_cp_d;
  logic              st_cp_q, st_cp_d;
  logic              div_end_c;

  assign div_end_c    = (div_q == DIV_W'(CLK_DIV - 1));
  assign shift_done_c = active_q && div_end_c && (half_q == HALF_W'(2 * N - 1));
  assign done_c       = active_q && div_end_c && (half_q == HALF_W'(LAST_HALF));

  // Half-period sequencing; pin levels are derived from the next state so they leave a flop.
  always_comb begin
    active_d = active_q;
    half_d   = half_q;
    div_d    = div_q;
    sreg_d   = sreg_q;
    ds_d     = 1'b0;
    sh_cp_d  = 1'b0;
    st_cp_d  = 1'b0;

    if (start) begin
      active_d = 1'b1;
      half_d   = '0;
      div_d    = '0;
      sreg_d   = data;
    end else if (active_q) begin
      if (div_end_c) begin
        div_d = '0;
        if (half_q == HALF_W'(LAST_HALF)) begin
          active_d = 1'b0;
        end else begin
          half_d = half_q + HALF_W'(1);
          // Advance to the next bit as SH_CP falls so DS only moves while SH_CP is low.
          if (half_q[0]) sreg_d = {sreg_q[N-2:0], 1'b0};
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    if (active_d) begin
      if (half_d < HALF_W'(2 * N)) begin
        ds_d    = sreg_d[N-1];
        sh_cp_d = half_d[0];
      end else begin
        st_cp_d = (half_d == HALF_W'(LAST_HALF));
      end
    end
  end

  // Serializer state and registered pin drivers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      half_q   <= '0;
      div_q    <= '0;
      sreg_q   <= '0;
      ds_q     <= 1'b0;
      sh_cp_q  <= 1'b0;
      st_cp_q  <= 1'b0;
    end else begin
      active_q <= active_d;
      half_q   <= half_d;
      div_q    <= div_d;
      sreg_q   <= sreg_d;
      ds_q     <= ds_d;
      sh_cp_q  <= sh_cp_d;
      st_cp_q  <= st_cp_d;
    end
  end

  assign ds    = ds_q;
  assign sh_cp = sh_cp_q;
  assign st_cp = st_cp_q;

endmodule

// File: rtl/hc595_scan_ctrl.sv
// Multiplexed 7-segment scan controller driving a pair of cascaded 74HC595s.
// Every SCAN_CYCLES a frame {sel, seg} for the next digit is shifted out and latched.
module hc595_scan_ctrl
  import hc595_pkg::*;
#(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned SCAN_CYCLES    = 50000,
  parameter bit          SEL_ACTIVE_LOW = 1'b1,
  localparam int unsigned AW            = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [SEG_W-1:0] wr_data,
  output logic             DS,
  output logic             SH_CP,
  output logic             ST_CP,
  output logic             busy
);

  localparam int unsigned CNT_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [AW-1:0]    digit_q, digit_d;
  logic             pend_q, pend_d;
  logic             busy_q, busy_d;
  logic [SEG_W-1:0] mem_q [DIGITS];
  logic [SEG_W-1:0] mem_d [DIGITS];
  logic             tick_c;
  logic             start_c;
  frame_t           frame_c;
  logic             shift_done_c;
  logic             done_c;

  // Free-running refresh timer; tick on the last count of each period.
  always_comb begin
    tick_c     = (scan_cnt_q == CNT_W'(SCAN_CYCLES - 1));
    scan_cnt_d = tick_c ? '0 : scan_cnt_q + CNT_W'(1);
  end

  // Pattern memory write port; addresses past DIGITS-1 match no entry.
  always_comb begin
    mem_d = mem_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (wr_en && (wr_addr == AW'(i))) mem_d[AW'(i)] = wr_data;
    end
  end

  // Frame for the current digit; sampled by the shifter at the end of LOAD.
  always_comb begin
    frame_c.sel = {SEL_W{SEL_ACTIVE_LOW}};
    frame_c.seg = BLANK_SEG;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (en && (digit_q == AW'(i))) begin
        frame_c.sel[3'(i)] = ~SEL_ACTIVE_LOW;
        frame_c.seg        = mem_q[AW'(i)];
      end
    end
  end

  // Frame sequencer: next state, one-deep tick pending, digit advance.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    digit_d = digit_q;
    start_c = 1'b0;

    if (tick_c && (state_q != ST_IDLE)) pend_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (tick_c || pend_q) begin
          state_d = ST_LOAD;
          pend_d  = pend_q && tick_c;
        end
      end
      ST_LOAD: begin
        start_c = 1'b1;
        state_d = ST_SHIFT;
        digit_d = (digit_q == AW'(DIGITS - 1)) ? '0 : digit_q + AW'(1);
      end
      ST_SHIFT: begin
        if (shift_done_c) state_d = ST_LATCH;
      end
      ST_LATCH: begin
        if (done_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Controller state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      scan_cnt_q <= '0;
      digit_q    <= '0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      mem_q      <= '{default: BLANK_SEG};
    end else begin
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      pend_q     <= pend_d;
      busy_q     <= busy_d;
      mem_q      <= mem_d;
    end
  end

  hc595_shifter #(
    .N       (FRAME_W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start_c),
    .data         (frame_c),
    .ds           (DS),
    .sh_cp        (SH_CP),
    .st_cp        (ST_CP),
    .shift_done_c (shift_done_c),
    .done_c       (done_c)
  );

  assign busy = busy_q;

endmodule

// File: tb/tb_hc595_scan_ctrl.sv
// Bench for hc595_scan_ctrl: a pin-level monitor rebuilds each frame from the
// SH_CP/ST_CP waveforms and a digit/pattern model predicts what it should be.
module tb_hc595_scan_ctrl;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned CLK_DIV = 2;
  localparam int          SCAN    = 100;
  localparam int          SCAN2   = 40;
  localparam int          LAT     = 1 + 34 * CLK_DIV;

  typedef struct {
    logic [15:0] data;
    int          bits;
    int          stw;
    int          start;
    int          fall;
    int          gap;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n, rst2_n, en, en2, wr_en, wr_en2;
  logic [1:0] wr_addr, wr_addr2;
  logic [7:0] wr_data, wr_data2;
  logic       ds0, sh0, st0, busy0, ds1, sh1, st1, busy1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  hc595_scan_ctrl #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .SCAN_CYCLES(SCAN), .SEL_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .DS(ds0), .SH_CP(sh0), .ST_CP(st0), .busy(busy0));

  hc595_scan_ctrl #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .SCAN_CYCLES(SCAN2), .SEL_ACTIVE_LOW(1'b1)) dut2 (
    .clk(clk), .rst_n(rst2_n), .en(en2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .DS(ds1), .SH_CP(sh1), .ST_CP(st1), .busy(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor state, index 0 = dut, 1 = dut2
  rec_t        q0[$];
  rec_t        q1[$];
  logic [15:0] m_sr[2];
  int          m_bits[2], m_stw[2], m_start[2], last_fall[2];
  logic        p_sh[2], p_st[2], p_busy[2], p_ds[2];
  int          st_rises[2], ds_hi_err[2], idle_ds_err[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_sr[k] = '0; m_bits[k] = 0; m_stw[k] = 0; m_start[k] = 0; last_fall[k] = -1000;
      p_sh[k] = 0; p_st[k] = 0; p_busy[k] = 0; p_ds[k] = 0;
      st_rises[k] = 0; ds_hi_err[k] = 0; idle_ds_err[k] = 0;
    end
  end

  task automatic mon_step(input int k, input logic ds, input logic sh, input logic st,
                          input logic bsy, input logic rn);
    rec_t r;
    if (!rn) begin
      m_sr[k] = '0; m_bits[k] = 0; m_stw[k] = 0;
      p_sh[k] = 0; p_st[k] = 0; p_busy[k] = 0; p_ds[k] = 0;
    end else begin
      if (bsy && !p_busy[k]) begin m_start[k] = cyc; m_bits[k] = 0; m_stw[k] = 0; end
      if (sh && !p_sh[k]) begin m_sr[k] = {m_sr[k][14:0], ds}; m_bits[k]++; end
      if (sh && p_sh[k] && (ds !== p_ds[k])) ds_hi_err[k]++;
      if (!bsy && (ds !== 1'b0)) idle_ds_err[k]++;
      if (st && !p_st[k]) st_rises[k]++;
      if (st) m_stw[k]++;
      if (!st && p_st[k]) begin
        r.data = m_sr[k]; r.bits = m_bits[k]; r.stw = m_stw[k];
        r.start = m_start[k]; r.fall = cyc; r.gap = m_start[k] - last_fall[k];
        last_fall[k] = cyc;
        if (k == 0) q0.push_back(r); else q1.push_back(r);
      end
      p_sh[k] = sh; p_st[k] = st; p_busy[k] = bsy; p_ds[k] = ds;
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, ds0, sh0, st0, busy0, rst_n);
    mon_step(1, ds1, sh1, st1, busy1, rst2_n);
  end

  // Reference model: pattern memory, digit to be shown next, next refresh slot
  logic [7:0] mdl_mem[DIGITS];
  int         model_digit;
  int         next_start;

  function automatic logic [15:0] model_frame(input int d, input logic e);
    logic [7:0] sel;
    if (!e) return 16'hFF00;
    sel = ~(8'h01 << d);
    return {sel, mdl_mem[d]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frame(output rec_t r);
    int n;
    n = 0;
    while (q0.size() == 0 && n < 400) begin @(posedge clk); n++; end
    checks++;
    assert (q0.size() != 0) else begin
      failures++;
      $error("FAIL frame_timeout observed=%0d frames expected=1 frame", q0.size());
    end
    if (q0.size() != 0) r = q0.pop_front();
    else r = '{data: 16'h0, bits: 0, stw: 0, start: 0, fall: 0, gap: 0};
  endtask

  task automatic expect_frame(input string tag, input logic [15:0] exp, output rec_t r);
    wait_frame(r);
    check({tag, "_data"},  32'(r.data), 32'(exp));
    check({tag, "_bits"},  r.bits, 16);
    check({tag, "_stw"},   r.stw, CLK_DIV);
    check({tag, "_lat"},   r.fall - r.start, LAT);
    check({tag, "_start"}, r.start, next_start);
    next_start  = r.start + SCAN;
    model_digit = (model_digit + 1) % DIGITS;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    mdl_mem[a] = d;
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    while (busy0 !== 1'b1 && n < 200) begin @(negedge clk); #1; n++; end
    check("busy_rise", 32'(busy0), 1);
  endtask

  logic [15:0] golden[5];
  logic [15:0] golden2[5];
  rec_t        r;
  logic [15:0] exp_f;
  int          rel0, rel, nw, d77, st_before, n;

  initial begin
    golden  = '{16'hFE3F, 16'hFD06, 16'hFB5B, 16'hF74F, 16'hFE3F};
    golden2 = '{16'hFE00, 16'hFD00, 16'hFB00, 16'hF700, 16'hFE00};
    for (int i = 0; i < DIGITS; i++) mdl_mem[i] = 8'h00;
    model_digit = 0;
    rst_n = 0; rst2_n = 0; en = 1; en2 = 1;
    wr_en = 0; wr_addr = 0; wr_data = 0; wr_en2 = 0; wr_addr2 = 0; wr_data2 = 0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ds", 32'(ds0), 0);
    check("rst_sh", 32'(sh0), 0);
    check("rst_st", 32'(st0), 0);
    check("rst_busy", 32'(busy0), 0);
    @(negedge clk);
    rst_n = 1; rst2_n = 1;
    rel0 = cyc;
    next_start = rel0 + SCAN;

    // Fixed patterns, first five frames
    do_write(2'd0, 8'h3F);
    do_write(2'd1, 8'h06);
    do_write(2'd2, 8'h5B);
    do_write(2'd3, 8'h4F);
    for (int i = 0; i < 5; i++) expect_frame("fixed", golden[i], r);

    // Blanked frame
    @(negedge clk); en = 0;
    expect_frame("blank", 16'hFF00, r);

    // Random patterns and enable
    for (int it = 0; it < 8; it++) begin
      nw = int'($urandom_range(0, 3));
      for (int w = 0; w < nw; w++) do_write(2'($urandom_range(0, 3)), 8'($urandom));
      @(negedge clk); en = ($urandom_range(0, 3) != 0);
      expect_frame("rand", model_frame(model_digit, en), r);
    end

    // Write to the digit being shifted, mid-frame
    @(negedge clk); en = 1;
    d77   = model_digit;
    exp_f = model_frame(d77, 1'b1);
    wait_busy();
    repeat (20) @(negedge clk);
    do_write(2'(d77), 8'h77);
    expect_frame("midwr_cur", exp_f, r);
    for (int j = 0; j < DIGITS; j++) expect_frame("midwr_next", model_frame(model_digit, 1'b1), r);
    check("midwr_seg77", 32'(r.data[7:0]), 32'h77);

    // Reset at bit 7 of a frame
    wait_busy();
    n = 0;
    while (m_bits[0] != 7 && n < 100) begin @(negedge clk); #1; n++; end
    check("abort_at_bit7", m_bits[0], 7);
    st_before = st_rises[0];
    rst_n = 0;
    #1;
    check("abort_ds", 32'(ds0), 0);
    check("abort_sh", 32'(sh0), 0);
    check("abort_st", 32'(st0), 0);
    check("abort_busy", 32'(busy0), 0);
    repeat (3) @(negedge clk);
    check("abort_no_frame", q0.size(), 0);
    check("abort_no_stcp", st_rises[0], st_before);
    rst_n = 1;
    rel = cyc;
    next_start  = rel + SCAN;
    model_digit = 0;
    for (int i = 0; i < DIGITS; i++) mdl_mem[i] = 8'h00;
    expect_frame("post_rst", model_frame(0, 1'b1), r);
    check("post_rst_seg", 32'(r.data[7:0]), 0);

    // Ticks while busy on the fast instance
    check("pend_frames", 32'(q1.size() >= 5), 1);
    for (int i = 0; i < 5; i++) begin
      if (i < q1.size()) begin
        check("pend_data", 32'(q1[i].data), 32'(golden2[i]));
        check("pend_lat", q1[i].fall - q1[i].start, LAT);
        if (i == 0) check("pend_first_start", q1[i].start, rel0 + SCAN2);
        else        check("pend_gap", q1[i].gap, 1);
      end
    end

    // Waveform rules over the whole run
    check("ds_stable_sh_high", ds_hi_err[0] + ds_hi_err[1], 0);
    check("ds_zero_idle", idle_ds_err[0] + idle_ds_err[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
